// File: rtl/prog_counter.sv
// Program counter with conditional branches and a return-address stack.
// Flags are used combinationally in the cycle pc_op is presented.
module prog_counter #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4,
    localparam int PTR_W      = $clog2(STACK_DEPTH),
    localparam int DEPTH_W    = PTR_W + 1
) (
    input  logic              clk,
    input  logic              pc_rst,
    input  logic              pc_en,
    input  logic [2:0]        pc_op,
    input  logic [ADDR_W-1:0] pc_target,
    input  logic              flag_c,
    input  logic              flag_z,
    input  logic              flag_b,
    output logic [ADDR_W-1:0] pc_addr,
    output logic              pc_taken,
    output logic [DEPTH_W-1:0] pc_depth,
    output logic              pc_stack_ovf,
    output logic              pc_stack_unf
);

    typedef enum logic [2:0] {
        OP_NEXT = 3'b000,
        OP_JMP  = 3'b001,
        OP_JC   = 3'b010,
        OP_JZ   = 3'b011,
        OP_JB   = 3'b100,
        OP_JNZ  = 3'b101,
        OP_CALL = 3'b110,
        OP_RET  = 3'b111
    } op_e;

    op_e               op;
    logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
    logic [ADDR_W-1:0] seq_addr;
    logic [ADDR_W-1:0] next_addr;
    logic [PTR_W-1:0]  wr_idx;
    logic [PTR_W-1:0]  top_idx;
    logic              full;
    logic              empty;
    logic              branch;
    logic              push;
    logic              pop;
    logic              set_ovf;
    logic              set_unf;

    assign op       = op_e'(pc_op);
    assign seq_addr = pc_addr + ADDR_W'(1);
    assign full     = (pc_depth == DEPTH_W'(STACK_DEPTH));
    assign empty    = (pc_depth == '0);
    // Low bits of depth index the next free slot; when full they wrap to 0.
    assign wr_idx   = pc_depth[PTR_W-1:0];
    assign top_idx  = wr_idx - PTR_W'(1);

    always_comb begin
        branch    = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        set_ovf   = 1'b0;
        set_unf   = 1'b0;
        next_addr = seq_addr;
        unique case (op)
            OP_NEXT: branch = 1'b0;
            OP_JMP:  branch = 1'b1;
            OP_JC:   branch = flag_c;
            OP_JZ:   branch = flag_z;
            OP_JB:   branch = flag_b;
            OP_JNZ:  branch = ~flag_z;
            OP_CALL: begin
                if (!full) begin
                    push   = 1'b1;
                    branch = 1'b1;
                end else begin
                    set_ovf = 1'b1;
                end
            end
            OP_RET: begin
                if (!empty) pop = 1'b1;
                else        set_unf = 1'b1;
            end
            default: branch = 1'b0;
        endcase
        if (branch) next_addr = pc_target;
        if (pop)    next_addr = stack_mem[top_idx];
    end

    always_ff @(posedge clk) begin
        if (pc_rst) begin
            pc_addr      <= '0;
            pc_taken     <= 1'b0;
            pc_depth     <= '0;
            pc_stack_ovf <= 1'b0;
            pc_stack_unf <= 1'b0;
        end else if (pc_en) begin
            pc_addr      <= next_addr;
            pc_taken     <= branch | pop;
            pc_stack_ovf <= pc_stack_ovf | set_ovf;
            pc_stack_unf <= pc_stack_unf | set_unf;
            if (push)
                pc_depth <= pc_depth + DEPTH_W'(1);
            else if (pop)
                pc_depth <= pc_depth - DEPTH_W'(1);
        end else begin
            pc_taken <= 1'b0;
        end
    end

    // Stack storage needs no reset: entries above pc_depth are never read.
    always_ff @(posedge clk) begin
        if (!pc_rst && pc_en && push)
            stack_mem[wr_idx] <= seq_addr;
    end

endmodule
